// File: rtl/route_lookup_arbiter_if.sv
// rtl/route_lookup_arbiter_if.sv - lookup request/response bundle between input ports and the arbiter
`ifndef ADDR_SZ
`define ADDR_SZ 5
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif
`ifndef NUM_NODES
`define NUM_NODES 16
`endif
`ifndef DIR_LOCAL
`define DIR_LOCAL 4
`endif

interface route_lookup_arbiter_if #(
  parameter int NUM_PORTS = 5
);
  logic [NUM_PORTS-1:0]          req;
  logic [NUM_PORTS*`ADDR_SZ-1:0] dest_addr;
  logic [NUM_PORTS-1:0]          ack;
  logic [`BITS_DIR-1:0]          route_dir;
  logic                          route_err;

  modport master (output req, dest_addr, input ack, route_dir, route_err);
  modport slave  (input req, dest_addr, output ack, route_dir, route_err);
endinterface

// File: rtl/route_lookup_arbiter.sv
// rtl/route_lookup_arbiter.sv - round-robin sharing of one combinational routing table among input ports
`ifndef ADDR_SZ
`define ADDR_SZ 5
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif
`ifndef NUM_NODES
`define NUM_NODES 16
`endif
`ifndef DIR_LOCAL
`define DIR_LOCAL 4
`endif

module route_lookup_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int NODE_ID   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  route_lookup_arbiter_if.slave lookup,
  output logic                 busy,
  output logic [`ADDR_SZ-1:0]  table_addr,
  input  logic [`BITS_DIR-1:0] table_data
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NODE_ID < 0 || NODE_ID >= `NUM_NODES) begin : g_bad_node_id
    $error("route_lookup_arbiter: NODE_ID out of range");
  end

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             pick_valid;
  logic             in_range;
  int               cand;
  logic [`ADDR_SZ-1:0] dest_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dest
    assign dest_arr[i] = lookup.dest_addr[i*`ADDR_SZ +: `ADDR_SZ];
  end

  // Walk from the farthest offset down so the port nearest rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (lookup.req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign in_range = ({1'b0, table_addr} < (`ADDR_SZ+1)'(`NUM_NODES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      lookup.ack       <= '0;
      lookup.route_dir <= '0;
      lookup.route_err <= 1'b0;
      busy             <= 1'b0;
      table_addr       <= '0;
      rr_ptr           <= '0;
      grant_idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_idx  <= pick_idx;
            table_addr <= dest_arr[pick_idx];
            busy       <= 1'b1;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          // Out-of-range destinations are delivered locally and flagged.
          if (in_range) begin
            lookup.route_dir <= table_data;
            lookup.route_err <= 1'b0;
          end else begin
            lookup.route_dir <= `BITS_DIR'(`DIR_LOCAL);
            lookup.route_err <= 1'b1;
          end
          lookup.ack <= NUM_PORTS'(1) << grant_idx;
          rr_ptr     <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
          state      <= RESP;
        end
        RESP: begin
          lookup.ack       <= '0;
          lookup.route_err <= 1'b0;
          busy             <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_route_lookup_arbiter.sv
// tb/tb_route_lookup_arbiter.sv - directed bench for route_lookup_arbiter with an XY routing table for node 5
`timescale 1ns/1ps
`ifndef ADDR_SZ
`define ADDR_SZ 5
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif
`ifndef NUM_NODES
`define NUM_NODES 16
`endif
`ifndef DIR_LOCAL
`define DIR_LOCAL 4
`endif

module tb_route_lookup_arbiter;
  localparam int NP      = 5;
  localparam int TBL_NODE = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 busy;
  logic [`ADDR_SZ-1:0]  table_addr;
  logic [`BITS_DIR-1:0] table_data;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  route_lookup_arbiter_if #(.NUM_PORTS(NP)) bus ();

  route_lookup_arbiter #(.NUM_PORTS(NP), .NODE_ID(TBL_NODE)) dut (
    .clk        (clk),
    .reset      (reset),
    .lookup     (bus.slave),
    .busy       (busy),
    .table_addr (table_addr),
    .table_data (table_data)
  );

  always #5 clk = ~clk;

  // 4x4 mesh, XY order; N=0 E=1 S=2 W=3 local=4
  function automatic logic [`BITS_DIR-1:0] xy_route(input logic [`ADDR_SZ-1:0] a);
    int dx, dy, cx, cy;
    if (int'(a) >= `NUM_NODES) return 3'd7;
    dx = int'(a) % 4; dy = int'(a) / 4;
    cx = TBL_NODE % 4; cy = TBL_NODE / 4;
    if (dx > cx) return 3'd1;
    if (dx < cx) return 3'd3;
    if (dy > cy) return 3'd2;
    if (dy < cy) return 3'd0;
    return 3'd4;
  endfunction

  always_comb table_data = xy_route(table_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic set_dest(input int p, input logic [`ADDR_SZ-1:0] a);
    bus.dest_addr[p*`ADDR_SZ +: `ADDR_SZ] = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("%s_onehot", tag), 32'($onehot0(bus.ack)), 32'd1);
      if (bus.ack != '0) begin
        at = cycle;
        break;
      end
    end
    if (at < 0) check($sformatf("%s_timeout", tag), 32'd0, 32'd1);
  endtask

  task automatic serve(input string tag, input int p, input logic [2:0] dir,
                       input logic err, input bit drop, output int at);
    wait_ack(tag, at);
    check($sformatf("%s_ack", tag), 32'(bus.ack), 32'(1 << p));
    check($sformatf("%s_dir", tag), 32'(bus.route_dir), 32'(dir));
    check($sformatf("%s_err", tag), 32'(bus.route_err), 32'(err));
    if (drop) bus.req[p] = 1'b0;
  endtask

  initial begin
    int at, prev, start;
    logic [2:0] exp_dir [NP];
    logic [`ADDR_SZ-1:0] dests [NP];
    dests   = '{5'd9, 5'd5, 5'd1, 5'd13, 5'd4};
    exp_dir = '{3'd2, 3'd4, 3'd0, 3'd2, 3'd3};

    bus.req       = '0;
    bus.dest_addr = '0;
    reset         = 1'b1;
    tick();
    tick();
    check("rst_ack",   32'(bus.ack), 32'd0);
    check("rst_dir",   32'(bus.route_dir), 32'd0);
    check("rst_err",   32'(bus.route_err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_taddr", 32'(table_addr), 32'd0);
    check("rst_rr",    32'(dut.rr_ptr), 32'd0);
    reset = 1'b0;

    // single request, port0 -> node 0 (west)
    set_dest(0, 5'd0);
    bus.req = 5'b00001;
    tick();
    check("t1_busy1", 32'(busy), 32'd1);
    check("t1_ack1",  32'(bus.ack), 32'd0);
    tick();
    check("t1_ack",   32'(bus.ack), 32'd1);
    check("t1_dir",   32'(bus.route_dir), 32'd3);
    check("t1_err",   32'(bus.route_err), 32'd0);
    check("t1_busy2", 32'(busy), 32'd1);
    bus.req = '0;
    tick();
    check("t1_ackclr",  32'(bus.ack), 32'd0);
    check("t1_busyclr", 32'(busy), 32'd0);
    check("t1_dirhold", 32'(bus.route_dir), 32'd3);
    check("t1_rr",      32'(dut.rr_ptr), 32'd1);

    // all ports at once, served 0..4 three cycles apart
    do_reset();
    for (int p = 0; p < NP; p++) set_dest(p, dests[p]);
    bus.req = 5'b11111;
    prev = 0;
    for (int p = 0; p < NP; p++) begin
      serve($sformatf("t2_p%0d", p), p, exp_dir[p], 1'b0, 1'b1, at);
      if (p > 0) check($sformatf("t2_gap%0d", p), 32'(at - prev), 32'd3);
      prev = at;
    end

    // grant port2 -> rr_ptr=3, then ports 0 and 4: port4 wins first
    set_dest(2, 5'd1);
    bus.req[2] = 1'b1;
    serve("t3_p2", 2, 3'd0, 1'b0, 1'b1, at);
    check("t3_rr", 32'(dut.rr_ptr), 32'd3);
    set_dest(0, 5'd0);
    set_dest(4, 5'd9);
    bus.req[0] = 1'b1;
    bus.req[4] = 1'b1;
    serve("t3_p4", 4, 3'd2, 1'b0, 1'b1, at);
    serve("t3_p0", 0, 3'd3, 1'b0, 1'b1, at);

    // out-of-range destination
    set_dest(1, 5'd16);
    bus.req[1] = 1'b1;
    serve("t4_p1", 1, 3'd4, 1'b1, 1'b1, at);
    tick();
    check("t4_errclr", 32'(bus.route_err), 32'd0);
    check("t4_ackclr", 32'(bus.ack), 32'd0);
    check("t4_dirhold", 32'(bus.route_dir), 32'd4);

    // reset in LOOKUP discards the lookup; held req is served again
    set_dest(3, 5'd13);
    bus.req[3] = 1'b1;
    tick();
    check("t5_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_ack",  32'(bus.ack), 32'd0);
    check("t5_busy0", 32'(busy), 32'd0);
    check("t5_dir",  32'(bus.route_dir), 32'd0);
    check("t5_rr",   32'(dut.rr_ptr), 32'd0);
    reset = 1'b0;
    start = cycle;
    serve("t5_p3", 3, 3'd2, 1'b0, 1'b1, at);
    check("t5_lat", 32'(at - start), 32'd2);

    // port2 held high: acked every 3 cycles
    set_dest(2, 5'd4);
    bus.req[2] = 1'b1;
    serve("t6_a0", 2, 3'd3, 1'b0, 1'b0, prev);
    for (int n = 1; n < 4; n++) begin
      serve($sformatf("t6_a%0d", n), 2, 3'd3, 1'b0, 1'b0, at);
      check($sformatf("t6_gap%0d", n), 32'(at - prev), 32'd3);
      prev = at;
    end
    bus.req = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/route_lookup_arbiter.md
Name: route_lookup_arbiter

Overview:
- Shares one per-node routing table among all input ports of a router. Each input port has a header flit waiting for a direction decision.
- Arbitrates round-robin among the ports' lookup requests and drives the table address. Registers the returned direction and acknowledges the winning port.
- Sits between the router's input-port controllers and the node's routing_table instance. The table is combinational: table_data follows table_addr in the same cycle.

Parameters:
- NUM_PORTS, 5, number of requesting input ports (N, E, S, W, local).
- NODE_ID, 0, node identifier; informational only, not used in logic.
- Widths come from the global defines `ADDR_SZ, `BITS_DIR, `NUM_NODES and `DIR_LOCAL.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_PORTS  per-port lookup request; held high until that port's ack.
- dest_addr  input  NUM_PORTS*`ADDR_SZ  flattened destination addresses; port i occupies bits [i*`ADDR_SZ +: `ADDR_SZ]; stable while req[i] is high.
- ack  output  NUM_PORTS  one-hot, one-cycle pulse; route_dir is valid for the acked port.
- route_dir  output  `BITS_DIR  registered output direction of the last completed lookup.
- route_err  output  1  pulses with ack when the destination is out of range.
- busy  output  1  high in LOOKUP and RESP states.
- table_addr  output  `ADDR_SZ  registered address to the routing table.
- table_data  input  `BITS_DIR  combinational data returned by the routing table.

Behaviour:
- Reset values (on any clk edge with reset high, including mid-lookup): state=IDLE, ack=0, route_dir=0, route_err=0, busy=0, table_addr=0, rr_ptr=0, grant_idx=0. Any in-flight lookup is discarded and no ack is issued.
- FSM has three states: IDLE, LOOKUP, RESP.
- IDLE, no req bit set: remain in IDLE.
- IDLE, any req bit set:
  - Select the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Latch that port's index into grant_idx.
  - Latch its dest_addr into table_addr.
  - Go to LOOKUP.
- LOOKUP:
  - If table_addr < `NUM_NODES: route_dir <= table_data, route_err <= 0.
  - Otherwise: route_dir <= `DIR_LOCAL, route_err <= 1; table_data is ignored.
  - ack[grant_idx] <= 1.
  - rr_ptr <= (grant_idx+1) mod NUM_PORTS.
  - Go to RESP.
- RESP:
  - ack and route_err are high for exactly this cycle; ack clears on exit, route_err clears on exit.
  - route_dir holds its value until the next LOOKUP.
  - Go to IDLE unconditionally.
- Latency: from req sampled in IDLE to ack high is 2 cycles. One lookup completes every 3 cycles at most.
- Requester rule: deassert req in the cycle after ack. If req stays high there, it is a new request, eligible in IDLE under round-robin.
- req changes outside IDLE are ignored; arbitration happens only in IDLE.
- Simultaneous requests: exactly one grant per IDLE decision. Ports not granted keep waiting and are never dropped.
- Starvation bound: a continuously requesting port is acked within NUM_PORTS grants.
- Dropping req after grant (protocol violation) does not abort the lookup; ack is still issued.
- Wrap-around: rr_ptr goes from NUM_PORTS-1 to 0.
- ack is always one-hot or zero, never multi-bit.
- busy = (state != IDLE).

Test Plan:
- Bench instantiates routing_table with NODE_ID=5 and connects it to table_addr/table_data.
- Reset, then req=5'b00001 with port0 dest=0 -> ack=5'b00001 two cycles later, route_dir=3, route_err=0, busy high for 2 cycles.
- All 5 ports request together, dests 9,5,1,13,4, held until each ack -> acks in order port0,1,2,3,4 with route_dir 2,4,0,2,3; successive acks 3 cycles apart.
- rr_ptr=3 after a grant to port2; then ports 0 and 4 request -> port4 acked first (route_dir per its dest), then port0.
- Port1 dest=`NUM_NODES (16, requires `ADDR_SZ>=5) -> ack[1] pulses, route_err=1 for one cycle, route_dir=`DIR_LOCAL (4).
- Assert reset during LOOKUP -> next cycle ack=0, busy=0, route_dir=0, rr_ptr=0. A held req is then re-served from scratch with the correct route_dir.
- Port2 holds req high continuously, no other requesters -> acked every 3 cycles; ack never wider than one bit.
